div_seq_iter: RTL and testbench



---
 rtl/div_seq_iter.sv | 133 +++++++++++++
 tb/tb_div_seq_iter.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/div_seq_iter.sv
// div_seq_iter: sequential restoring divider, one quotient bit per clock.
// Unsigned or two's-complement operation, with start/complete handshake and
// hold (stall) control. Results are truncated toward zero.
// Optional build macro: DIV_SEQ_EARLY_ZERO_EN. When defined, a zero divisor
// is resolved at the start edge and the results appear one cycle later.
module div_seq_iter #(
    parameter int a_width = 8,
    parameter int b_width = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               hold,
    input  logic               start,
    input  logic               tc,
    input  logic [a_width-1:0] a,
    input  logic [b_width-1:0] b,
    output logic               complete,
    output logic               divide_by_0,
    output logic [a_width-1:0] quotient,
    output logic [b_width-1:0] remainder
);

    localparam int CW = $clog2(a_width + 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t             state, state_nx;
    logic [CW-1:0]      cnt;
    logic               tc_r, sign_a, sign_b, b_zero, ez_pend;
    // dvd starts as the dividend and fills up with quotient bits from the LSB
    logic [a_width-1:0] dvd;
    logic [b_width-1:0] dvs, a_low;
    logic [b_width:0]   prem;

    logic [a_width-1:0] a_mag, dvd_nx, q_fix;
    logic [b_width-1:0] b_mag, r_fix;
    logic [b_width:0]   shifted, diff, prem_nx;
    logic               q_bit, step, zero_now;

    // Operand magnitudes; the most negative value maps onto itself, which
    // read as unsigned is exactly its magnitude.
    always_comb begin
        a_mag = (tc && a[a_width-1]) ? -a : a;
        b_mag = (tc && b[b_width-1]) ? -b : b;
`ifdef DIV_SEQ_EARLY_ZERO_EN
        zero_now = (b == '0);
`else
        zero_now = 1'b0;
`endif
    end

    // One restoring step plus the sign fix-up applied on the final step.
    always_comb begin
        step    = (state == BUSY) && !start && !hold;
        shifted = {prem[b_width-1:0], dvd[a_width-1]};
        diff    = shifted - {1'b0, dvs};
        q_bit   = (shifted >= {1'b0, dvs});
        prem_nx = q_bit ? diff : shifted;
        dvd_nx  = {dvd[a_width-2:0], q_bit};
        q_fix   = (tc_r && (sign_a ^ sign_b)) ? -dvd_nx : dvd_nx;
        r_fix   = (tc_r && sign_a) ? -prem_nx[b_width-1:0] : prem_nx[b_width-1:0];
    end

    // FSM next state: start always (re)loads, the last unstalled step returns to IDLE.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (start && !zero_now) state_nx = BUSY;
            BUSY: begin
                if (start)
                    state_nx = zero_now ? IDLE : BUSY;
                else if (step && cnt == CW'(1))
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Operand load, iteration and result registers; outputs move only at finish.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            tc_r        <= 1'b0;
            sign_a      <= 1'b0;
            sign_b      <= 1'b0;
            b_zero      <= 1'b0;
            ez_pend     <= 1'b0;
            dvd         <= '0;
            dvs         <= '0;
            a_low       <= '0;
            prem        <= '0;
            complete    <= 1'b1;
            divide_by_0 <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
        end else if (start) begin
            tc_r     <= tc;
            sign_a   <= a[a_width-1];
            sign_b   <= b[b_width-1];
            b_zero   <= (b == '0);
            ez_pend  <= zero_now;
            dvd      <= a_mag;
            dvs      <= b_mag;
            a_low    <= a[b_width-1:0];
            prem     <= '0;
            cnt      <= zero_now ? '0 : CW'(a_width);
            complete <= 1'b0;
        end else if (ez_pend) begin
            ez_pend     <= 1'b0;
            divide_by_0 <= 1'b1;
            quotient    <= '1;
            remainder   <= a_low;
            complete    <= 1'b1;
        end else if (step) begin
            prem <= prem_nx;
            dvd  <= dvd_nx;
            cnt  <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
                complete    <= 1'b1;
                divide_by_0 <= b_zero;
                quotient    <= b_zero ? '1 : q_fix;
                remainder   <= b_zero ? a_low : r_fix;
            end
        end
    end

endmodule

// File: tb/tb_div_seq_iter.sv
// Directed bench for div_seq_iter (8/8 widths) with a scoreboard queue.
// Expected results come from integer division in the bench.
module tb_div_seq_iter;

    logic       clk = 1'b0;
    logic       rst_n, hold, start, tc;
    logic [7:0] a, b;
    logic       complete, divide_by_0;
    logic [7:0] quotient, remainder;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] q;
        logic [7:0] r;
        logic       dz;
        int         lat;
    } exp_t;

    exp_t sb[$];
    exp_t prev;

    div_seq_iter #(.a_width(8), .b_width(8)) dut (
        .clk(clk), .rst_n(rst_n), .hold(hold), .start(start), .tc(tc),
        .a(a), .b(b), .complete(complete), .divide_by_0(divide_by_0),
        .quotient(quotient), .remainder(remainder)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(logic [7:0] x, logic [7:0] y, logic t);
        exp_t e;
        int   sx, sy;
        if (y == 8'd0) begin
            e.q  = 8'hFF;
            e.r  = x;
            e.dz = 1'b1;
`ifdef DIV_SEQ_EARLY_ZERO_EN
            e.lat = 1;
`else
            e.lat = 8;
`endif
        end else begin
            sx    = t ? int'($signed(x)) : int'(x);
            sy    = t ? int'($signed(y)) : int'(y);
            e.q   = 8'(sx / sy);
            e.r   = 8'(sx % sy);
            e.dz  = 1'b0;
            e.lat = 8;
        end
        return e;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a start through edge E0; returns just after E0.
    task automatic do_start(logic [7:0] x, logic [7:0] y, logic t, bit push);
        a = x; b = y; tc = t; start = 1'b1;
        if (push) sb.push_back(model(x, y, t));
        tick();
        start = 1'b0;
        chk("busy_after_start", complete, 1'b0);
    endtask

    // Wait (bounded) for complete; 'done' counts edges already past E0.
    task automatic wait_done(int done, int lat_add, string tag);
        int   cyc;
        exp_t e;
        cyc = done;
        while (!complete && cyc < 100) begin
            tick();
            cyc++;
        end
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s observed empty_queue expected entry", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, "_lat"}, cyc, e.lat + lat_add);
            chk({tag, "_q"}, quotient, e.q);
            chk({tag, "_r"}, remainder, e.r);
            chk({tag, "_dz"}, divide_by_0, e.dz);
            prev = e;
        end
    endtask

    task automatic run(logic [7:0] x, logic [7:0] y, logic t, string tag);
        do_start(x, y, t, 1'b1);
        wait_done(0, 0, tag);
        tick();
    endtask

    initial begin
        rst_n = 1'b0; hold = 1'b0; start = 1'b0; tc = 1'b0; a = '0; b = '0;
        tick(); tick();
        chk("rst_complete", complete, 1'b1);
        chk("rst_dz", divide_by_0, 1'b0);
        chk("rst_q", quotient, 8'd0);
        chk("rst_r", remainder, 8'd0);
        rst_n = 1'b1;
        tick();

        // Plain unsigned, then signed cases including the overflow wrap.
        run(8'd200, 8'd7, 1'b0, "u200_7");
        chk("u200_7_const_q", quotient, 8'd28);
        chk("u200_7_const_r", remainder, 8'd4);
        run(8'h9C, 8'd7, 1'b1, "s_m100_7");
        chk("s_m100_7_const_q", quotient, 8'hF2);
        chk("s_m100_7_const_r", remainder, 8'hFE);
        run(8'h80, 8'hFF, 1'b1, "s_ovf");
        chk("s_ovf_const_q", quotient, 8'h80);

        // Divide by zero, unsigned and signed, then a clean division.
        run(8'd5, 8'd0, 1'b0, "u_div0");
        chk("u_div0_const_q", quotient, 8'hFF);
        chk("u_div0_const_r", remainder, 8'd5);
        run(8'h85, 8'd0, 1'b1, "s_div0");
        run(8'd9, 8'd3, 1'b0, "after_div0");

        // Hold for three edges mid-operation; outputs keep the prior result.
        do_start(8'd200, 8'd7, 1'b0, 1'b1);
        tick(); tick();
        hold = 1'b1;
        tick(); tick(); tick();
        hold = 1'b0;
        chk("hold_keep_q", quotient, prev.q);
        chk("hold_keep_complete", complete, 1'b0);
        wait_done(5, 3, "hold");
        tick();

        // Restart at E4 with a new operation; the first result is dropped.
        do_start(8'd200, 8'd7, 1'b0, 1'b0);
        tick(); tick(); tick();
        do_start(8'd100, 8'd9, 1'b0, 1'b1);
        chk("restart_keep_q", quotient, prev.q);
        wait_done(0, 0, "restart");
        chk("restart_total_q", quotient, 8'd11);
        chk("restart_total_r", remainder, 8'd1);
        tick();

        // Asynchronous reset mid-operation.
        do_start(8'd200, 8'd7, 1'b0, 1'b0);
        tick(); tick(); tick(); tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_complete", complete, 1'b1);
        chk("midrst_q", quotient, 8'd0);
        chk("midrst_r", remainder, 8'd0);
        chk("midrst_dz", divide_by_0, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();
        run(8'd50, 8'd5, 1'b0, "post_rst");

        // A few random operands in both modes.
        for (int i = 0; i < 8; i++) begin
            run(8'($urandom_range(0, 255)), 8'($urandom_range(1, 255)),
                1'($urandom_range(0, 1)), "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
